// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit: shift-add multiply and restoring divide on
// operand magnitudes, one bit per cycle, with a start/done handshake and abort.
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic             sign,
  input  logic             abort,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam int RW = WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    FIXUP,
    DONE
  } state_e;

  state_e             state_q, state_d;
  logic               op_q, op_d;
  logic               negq_q, negq_d;
  logic               negr_q, negr_d;
  logic               dz_q, dz_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH:0]     rem_q, rem_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               div_zero_q, div_zero_d;

  logic [WIDTH-1:0]   mag_a, mag_b;
  logic               b_zero;
  logic [WIDTH:0]     add_sum;
  logic [WIDTH+1:0]   shifted;
  logic               ge;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  always_comb begin
    mag_a    = (sign && a[WIDTH-1]) ? -a : a;
    mag_b    = (sign && b[WIDTH-1]) ? -b : b;
    b_zero   = (b == '0);
    // Multiply: acc = {partial product, remaining multiplier bits}
    add_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + ({1'b0, dvs_q} & {RW{acc_q[0]}});
    // Divide: acc low half shifts dividend bits out MSB first, quotient bits in
    shifted  = {rem_q, acc_q[WIDTH-1]};
    ge       = (shifted >= {2'b00, dvs_q});
    prod_fix = negq_q ? -acc_q : acc_q;
    quo_fix  = negq_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_fix  = negr_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    negq_d     = negq_q;
    negr_d     = negr_q;
    dz_d       = dz_q;
    cnt_d      = cnt_q;
    dvs_d      = dvs_q;
    acc_d      = acc_q;
    rem_d      = rem_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    div_zero_d = div_zero_q;

    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          op_d       = op;
          negq_d     = sign & (a[WIDTH-1] ^ b[WIDTH-1]);
          negr_d     = sign & a[WIDTH-1];
          dz_d       = op & b_zero;
          cnt_d      = CNT_W'(WIDTH - 1);
          dvs_d      = op ? mag_b : mag_a;
          // A zero divisor keeps the raw dividend so it can be returned as-is
          acc_d      = {{WIDTH{1'b0}}, op ? (b_zero ? a : mag_a) : mag_b};
          rem_d      = '0;
          div_zero_d = 1'b0;
          busy_d     = 1'b1;
          state_d    = ITER;
        end
      end

      ITER: begin
        if (abort) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end else if (dz_q) begin
          hi_d       = acc_q[WIDTH-1:0];
          lo_d       = '1;
          div_zero_d = 1'b1;
          busy_d     = 1'b0;
          state_d    = DONE;
        end else begin
          if (op_q) begin
            rem_d = ge ? RW'(shifted - {2'b00, dvs_q}) : shifted[WIDTH:0];
            acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], ge};
          end else begin
            acc_d = {add_sum, acc_q[WIDTH-1:1]};
          end
          if (cnt_q == '0) begin
            state_d = FIXUP;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end

      FIXUP: begin
        busy_d = 1'b0;
        if (abort) begin
          state_d = IDLE;
        end else begin
          if (op_q) begin
            lo_d = quo_fix;
            hi_d = rem_fix;
          end else begin
            {hi_d, lo_d} = prod_fix;
          end
          state_d = DONE;
        end
      end

      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      op_q       <= 1'b0;
      negq_q     <= 1'b0;
      negr_q     <= 1'b0;
      dz_q       <= 1'b0;
      cnt_q      <= '0;
      dvs_q      <= '0;
      acc_q      <= '0;
      rem_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      negq_q     <= negq_d;
      negr_q     <= negr_d;
      dz_q       <= dz_d;
      cnt_q      <= cnt_d;
      dvs_q      <= dvs_d;
      acc_q      <= acc_d;
      rem_q      <= rem_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign hi       = hi_q;
  assign lo       = lo_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = div_zero_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit at WIDTH=32 and WIDTH=8: arithmetic reference model
// with a per-cycle compare, plus directed vectors with literal expectations.
module tb_muldiv_unit;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        rst0, start0, op0, sg0, abort0;
  logic [31:0] a0, b0, hi0, lo0;
  logic        busy0, done0, dz0;
  logic        rst1, start1, op1, sg1, abort1;
  logic [7:0]  a1, b1, hi1, lo1;
  logic        busy1, done1, dz1;

  muldiv_unit #(.WIDTH(32)) dut32 (
    .clock(clock), .reset(rst0), .start(start0), .op(op0), .sign(sg0),
    .abort(abort0), .a(a0), .b(b0), .hi(hi0), .lo(lo0), .busy(busy0),
    .done(done0), .div_zero(dz0)
  );

  muldiv_unit #(.WIDTH(8)) dut8 (
    .clock(clock), .reset(rst1), .start(start1), .op(op1), .sign(sg1),
    .abort(abort1), .a(a1), .b(b1), .hi(hi1), .lo(lo1), .busy(busy1),
    .done(done1), .div_zero(dz1)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference result {hi, lo}, each right-aligned in 32 bits, from plain arithmetic
  function automatic logic [63:0] ref_calc(input int w, input logic o, input logic s,
                                           input logic [31:0] av, input logic [31:0] bv);
    logic [63:0] mask, pu, hv, lv;
    longint ua, ub, sa, sb, q, r;
    mask = (64'd1 << w) - 64'd1;
    ua = longint'({32'd0, av} & mask);
    ub = longint'({32'd0, bv} & mask);
    sa = (s && av[w-1]) ? ua - (longint'(1) << w) : ua;
    sb = (s && bv[w-1]) ? ub - (longint'(1) << w) : ub;
    if (!o) begin
      pu = sa * sb;
      hv = (pu >> w) & mask;
      lv = pu & mask;
    end else if (ub == 0) begin
      hv = ua;
      lv = mask;
    end else begin
      q  = sa / sb;
      r  = sa % sb;
      pu = q;
      lv = pu & mask;
      pu = r;
      hv = pu & mask;
    end
    return {hv[31:0], lv[31:0]};
  endfunction

  logic [31:0] m_hi [2];
  logic [31:0] m_lo [2];
  logic [31:0] m_rhi [2];
  logic [31:0] m_rlo [2];
  logic        m_busy [2];
  logic        m_done [2];
  logic        m_dz [2];
  logic        m_rdz [2];
  logic        m_indone [2];
  int          m_rem [2];

  task automatic model_clear(input int i);
    m_hi[i] = '0; m_lo[i] = '0; m_busy[i] = 1'b0; m_done[i] = 1'b0;
    m_dz[i] = 1'b0; m_indone[i] = 1'b0; m_rem[i] = 0;
  endtask

  // m_rem counts edges until the result becomes visible on hi/lo
  task automatic model_step(input int i, input int w, input logic st, input logic o,
                            input logic s, input logic ab,
                            input logic [31:0] av, input logic [31:0] bv);
    logic [63:0] r;
    if (m_indone[i]) begin
      m_indone[i] = 1'b0;
      m_done[i]   = 1'b1;
    end else begin
      m_done[i] = 1'b0;
      if (m_busy[i]) begin
        if (ab) m_busy[i] = 1'b0;
        else if (m_rem[i] == 1) begin
          m_hi[i] = m_rhi[i]; m_lo[i] = m_rlo[i]; m_dz[i] = m_rdz[i];
          m_busy[i] = 1'b0; m_indone[i] = 1'b1;
        end else m_rem[i]--;
      end else if (st && !ab) begin
        r = ref_calc(w, o, s, av, bv);
        m_rhi[i] = r[63:32];
        m_rlo[i] = r[31:0];
        m_rdz[i] = o && (bv == 32'd0);
        m_busy[i] = 1'b1;
        m_dz[i]   = 1'b0;
        m_rem[i]  = m_rdz[i] ? 1 : w + 1;
      end
    end
  endtask

  initial begin
    model_clear(0);
    model_clear(1);
    forever begin
      @(posedge clock or negedge rst0 or negedge rst1);
      if (!rst0) model_clear(0);
      else if (clock) model_step(0, 32, start0, op0, sg0, abort0, a0, b0);
      if (!rst1) model_clear(1);
      else if (clock) model_step(1, 8, start1, op1, sg1, abort1, {24'd0, a1}, {24'd0, b1});
    end
  end

  initial begin
    forever begin
      @(negedge clock);
      chk("hi32", hi0, m_hi[0]);
      chk("lo32", lo0, m_lo[0]);
      chk("busy32", 32'(busy0), 32'(m_busy[0]));
      chk("done32", 32'(done0), 32'(m_done[0]));
      chk("dz32", 32'(dz0), 32'(m_dz[0]));
      chk("hi8", {24'd0, hi1}, m_hi[1]);
      chk("lo8", {24'd0, lo1}, m_lo[1]);
      chk("busy8", 32'(busy1), 32'(m_busy[1]));
      chk("done8", 32'(done1), 32'(m_done[1]));
      chk("dz8", 32'(dz1), 32'(m_dz[1]));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Called at posedge+1; returns at posedge+1 of the edge that made done visible
  task automatic run_op(input int i, input logic o, input logic s,
                        input logic [31:0] av, input logic [31:0] bv, output int lat);
    logic d;
    if (i == 0) begin start0 = 1'b1; op0 = o; sg0 = s; a0 = av; b0 = bv; end
    else begin start1 = 1'b1; op1 = o; sg1 = s; a1 = av[7:0]; b1 = bv[7:0]; end
    @(posedge clock); #1;
    start0 = 1'b0; start1 = 1'b0;
    lat = 0;
    d = 1'b0;
    while (lat < 100 && !d) begin
      @(posedge clock); #1;
      lat++;
      d = (i == 0) ? done0 : done1;
    end
    if (!d) chk("done_timeout", 32'(d), 32'd1);
  endtask

  task automatic count_done(input int n, output int seen);
    seen = 0;
    repeat (n) begin
      @(posedge clock); #1;
      if (done0) seen++;
    end
  endtask

  logic        tv_op [6]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
  logic        tv_sg [6]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
  logic [31:0] tv_a  [6]  = '{32'd7, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'd5};
  logic [31:0] tv_b  [6]  = '{32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'd1, 32'd0, 32'h8000_0000, 32'd10};

  initial begin
    int lat, seen;
    rst0 = 1'b1; rst1 = 1'b1;
    {start0, op0, sg0, abort0, a0, b0} = '0;
    {start1, op1, sg1, abort1, a1, b1} = '0;
    #1;
    rst0 = 1'b0; rst1 = 1'b0;
    @(negedge clock);
    chk("rst_hi", hi0, 32'd0);
    chk("rst_lo", lo0, 32'd0);
    chk("rst_busy", 32'(busy0), 32'd0);
    chk("rst_done", 32'(done0), 32'd0);
    chk("rst_dz", 32'(dz0), 32'd0);
    #2;
    rst0 = 1'b1; rst1 = 1'b1;
    @(posedge clock); #1;

    run_op(0, 1'b0, 1'b1, 32'hFFFF_FFFD, 32'd7, lat);
    chk("mul_s_lat", 32'(lat), 32'd34);
    chk("mul_s_hi", hi0, 32'hFFFF_FFFF);
    chk("mul_s_lo", lo0, 32'hFFFF_FFEB);
    @(posedge clock); #1;
    chk("mul_s_done_width", 32'(done0), 32'd0);

    run_op(0, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
    chk("mulu_max_hi", hi0, 32'hFFFF_FFFE);
    chk("mulu_max_lo", lo0, 32'h0000_0001);
    run_op(0, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
    chk("muls_m1_hi", hi0, 32'd0);
    chk("muls_m1_lo", lo0, 32'd1);

    run_op(0, 1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, lat);
    chk("div_s_lo", lo0, 32'hFFFF_FFFD);
    chk("div_s_hi", hi0, 32'hFFFF_FFFF);
    run_op(0, 1'b1, 1'b0, 32'd100, 32'd7, lat);
    chk("divu_lo", lo0, 32'd14);
    chk("divu_hi", hi0, 32'd2);
    chk("divu_lat", 32'(lat), 32'd34);

    run_op(0, 1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, lat);
    chk("div_ovf_lo", lo0, 32'h8000_0000);
    chk("div_ovf_hi", hi0, 32'd0);
    chk("div_ovf_dz", 32'(dz0), 32'd0);

    run_op(0, 1'b1, 1'b0, 32'd1234, 32'd0, lat);
    chk("dz_lat", 32'(lat), 32'd2);
    chk("dz_flag", 32'(dz0), 32'd1);
    chk("dz_hi", hi0, 32'd1234);
    chk("dz_lo", lo0, 32'hFFFF_FFFF);
    run_op(0, 1'b1, 1'b1, 32'd100, 32'hFFFF_FFF9, lat);
    chk("dz_cleared", 32'(dz0), 32'd0);
    chk("div_sn_lo", lo0, 32'hFFFF_FFF2);
    chk("div_sn_hi", hi0, 32'd2);

    for (int k = 0; k < 6; k++) begin
      run_op(0, tv_op[k], tv_sg[k], tv_a[k], tv_b[k], lat);
      chk("table_lat", 32'(lat), (tv_op[k] && tv_b[k] == 32'd0) ? 32'd2 : 32'd34);
    end
    run_op(0, 1'b1, 1'b1, 32'd100, 32'hFFFF_FFF9, lat);

    // abort sampled at iteration 10
    start0 = 1'b1; op0 = 1'b0; sg0 = 1'b0; a0 = 32'd12345; b0 = 32'd6789;
    @(posedge clock); #1;
    start0 = 1'b0;
    repeat (9) @(posedge clock);
    #1 abort0 = 1'b1;
    @(posedge clock); #1;
    abort0 = 1'b0;
    chk("abort_busy", 32'(busy0), 32'd0);
    count_done(40, seen);
    chk("abort_no_done", 32'(seen), 32'd0);
    chk("abort_hi", hi0, 32'd2);
    chk("abort_lo", lo0, 32'hFFFF_FFF2);

    start0 = 1'b1; abort0 = 1'b1; a0 = 32'd3; b0 = 32'd3;
    @(posedge clock); #1;
    start0 = 1'b0; abort0 = 1'b0;
    chk("abort_start_busy", 32'(busy0), 32'd0);
    count_done(4, seen);
    chk("abort_start_no_done", 32'(seen), 32'd0);

    // second start mid-operation must not disturb the first
    start0 = 1'b1; op0 = 1'b0; sg0 = 1'b0; a0 = 32'd9; b0 = 32'd11;
    @(posedge clock); #1;
    start0 = 1'b0;
    lat = 0;
    while (lat < 100 && !done0) begin
      if (lat == 5) begin start0 = 1'b1; a0 = 32'd5; b0 = 32'd5; end
      else start0 = 1'b0;
      @(posedge clock); #1;
      lat++;
    end
    start0 = 1'b0;
    chk("midstart_lat", 32'(lat), 32'd34);
    chk("midstart_lo", lo0, 32'd99);
    chk("midstart_hi", hi0, 32'd0);

    run_op(0, 1'b1, 1'b0, 32'd77, 32'd0, lat);
    start0 = 1'b1; op0 = 1'b0; sg0 = 1'b1; a0 = 32'd5; b0 = 32'd5;
    @(posedge clock); #1;
    start0 = 1'b0;
    repeat (8) @(posedge clock);
    @(negedge clock); #2;
    rst0 = 1'b0;
    @(negedge clock);
    chk("rst_mid_hi", hi0, 32'd0);
    chk("rst_mid_lo", lo0, 32'd0);
    chk("rst_mid_busy", 32'(busy0), 32'd0);
    chk("rst_mid_dz", 32'(dz0), 32'd0);
    #2 rst0 = 1'b1;
    @(posedge clock); #1;
    count_done(40, seen);
    chk("rst_mid_no_done", 32'(seen), 32'd0);

    run_op(1, 1'b0, 1'b1, 32'h80, 32'h80, lat);
    chk("w8_mul_lat", 32'(lat), 32'd10);
    chk("w8_mul_hi", {24'd0, hi1}, 32'h40);
    chk("w8_mul_lo", {24'd0, lo1}, 32'h00);
    run_op(1, 1'b1, 1'b1, 32'h80, 32'hFF, lat);
    chk("w8_ovf_lo", {24'd0, lo1}, 32'h80);
    chk("w8_ovf_hi", {24'd0, hi1}, 32'h00);
    run_op(1, 1'b0, 1'b0, 32'hFF, 32'hFF, lat);
    chk("w8_mulu_hi", {24'd0, hi1}, 32'hFE);
    chk("w8_mulu_lo", {24'd0, lo1}, 32'h01);
    run_op(1, 1'b1, 1'b0, 32'h2A, 32'h00, lat);
    chk("w8_dz_lat", 32'(lat), 32'd2);
    chk("w8_dz_hi", {24'd0, hi1}, 32'h2A);

    repeat (3) @(posedge clock);
    @(negedge clock); #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Parametrised iterative multiply/divide unit for the multicycle datapath. It replaces the controller's hard-wired 31-step MULT/DIV counter with a self-timed block behind a start/done handshake. It supports signed and unsigned modes, reports divide-by-zero, and supports abort. The controller starts the unit from its execute state and waits for `done`. The unit drives the HI/LO register write data directly.

## Interface
- `WIDTH`, default 32: operand width. Must be ≥ 4. HI and LO are each `WIDTH` bits.
- `CNT_W`, default `$clog2(WIDTH)+1`: iteration counter width. Derived; do not override.

Ports:
- `clock`, in, 1: single clock. All state updates on the rising edge.
- `reset`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: begin an operation. Sampled only in IDLE.
- `op`, in, 1: operation select. 0 = multiply, 1 = divide.
- `sign`, in, 1: 1 = signed (MULT/DIV), 0 = unsigned (MULTU/DIVU).
- `abort`, in, 1: synchronous cancel of an in-flight operation.
- `a`, in, WIDTH: multiplicand or dividend. Captured at start.
- `b`, in, WIDTH: multiplier or divisor. Captured at start.
- `hi`, out, WIDTH: product upper half, or remainder.
- `lo`, out, WIDTH: product lower half, or quotient.
- `busy`, out, 1: high while an operation is in flight.
- `done`, out, 1: one-cycle pulse; `hi`/`lo` are updated and valid.
- `div_zero`, out, 1: sticky flag, set when a divide was started with `b` = 0.

## Operation
- States: IDLE, ITER, FIXUP, DONE.
- IDLE, `start`=1: capture `op`, `sign`, `a`, `b`.
  - Form magnitudes: in signed mode, |x| for each operand; otherwise the raw value.
  - Record `neg_q` = sign(a) XOR sign(b). Record `neg_r` = sign(a).
  - Load counter with `WIDTH`-1. Go to ITER.
  - Clear `div_zero` on any accepted start.
- Divide with `b`=0: skip ITER and go straight to DONE.
  - `hi` = `a` unchanged; `lo` = all ones; `div_zero` = 1.
- ITER, multiply: unsigned shift-add on magnitudes into a 2·WIDTH accumulator, one multiplier bit per cycle, LSB first.
- ITER, divide: restoring division on magnitudes, one quotient bit per cycle, MSB first. The remainder register is WIDTH+1 bits.
- ITER: counter decrements each cycle. Go to FIXUP after the cycle where the counter is 0, i.e. exactly `WIDTH` iterations.
- FIXUP, multiply: in signed mode with `neg_q`, negate the 2·WIDTH product. Write the result to `hi`:`lo`.
- FIXUP, divide:
  - Negate the quotient if `neg_q`; negate the remainder if `neg_r`.
  - `lo` = quotient, `hi` = remainder.
  - Quotient truncates toward zero; the remainder takes the dividend's sign.
- Overflow case, signed most-negative ÷ −1: natural wrap. `lo` = most-negative, `hi` = 0. No flag.
- FIXUP → DONE; DONE → IDLE.
- `hi`/`lo` change only on the FIXUP edge or the divide-by-zero edge. They hold between operations.
- `start` while busy: ignored. No effect on the operation in flight.
- `abort` in ITER or FIXUP: return to IDLE on the next edge. `hi`/`lo`/`div_zero` are unchanged and no `done` is produced.
- `abort` in IDLE or DONE: no effect. `abort` and `start` together in IDLE: abort wins and the start is dropped.
- Reset asserted mid-operation: the operation is discarded immediately.
- Reset values: state IDLE, `hi`=0, `lo`=0, `busy`=0, `done`=0, `div_zero`=0, counter 0.

## Timing
- `busy` is registered: high from the edge that accepts `start` until the edge entering DONE.
- `done` is registered: high for exactly the DONE cycle, with `busy`=0 in that cycle.
- Normal latency, start accepted at edge 0:
  - ITER on edges 1..WIDTH.
  - FIXUP registers `hi`/`lo` on edge WIDTH+1.
  - `done`=1 after edge WIDTH+2.
  - `done` is visible WIDTH+2 cycles after start (34 for WIDTH=32).
- Divide-by-zero latency: results and `div_zero` registered at edge 1; `done`=1 after edge 2.
- A new `start` is accepted in DONE's following IDLE cycle. Minimum issue interval is WIDTH+3 cycles.
- No combinational path from any input to any output.

## Test plan
- Signed multiply, WIDTH=32, `a`=−3, `b`=7 → `hi`=FFFFFFFF, `lo`=FFFFFFEB; `done` exactly 34 cycles after start, one cycle wide.
- Unsigned multiply, `a`=`b`=FFFFFFFF → `hi`=FFFFFFFE, `lo`=00000001. Repeat with `sign`=1 → `hi`=0, `lo`=1.
- Signed divide, `a`=−7, `b`=2 → `lo`=FFFFFFFD, `hi`=FFFFFFFF. Unsigned divide, `a`=100, `b`=7 → `lo`=14, `hi`=2.
- Signed divide, `a`=80000000, `b`=FFFFFFFF → `lo`=80000000, `hi`=0, `div_zero`=0.
- Divide, `a`=1234, `b`=0 → `div_zero`=1, `hi`=1234, `lo`=FFFFFFFF, `done` 2 cycles after start. The next valid start clears `div_zero`.
- Each of the following → `hi`/`lo` unchanged, `done` never pulses, `busy`=0 next cycle:
  - `abort` at iteration 10.
  - `start` pulsed mid-op (must be ignored).
  - `reset` low mid-op (must clear all outputs to 0).
- Repeat with WIDTH=8: signed multiply, `a`=−128, `b`=−128 → `hi`:`lo`=4000; `done` after 10 cycles.
